split: RTL and testbench
========================

# split

Two-channel stream de-serializer for the HMM-Viterbi datapath. It accepts one serialized frame of 2·ROMSIZE signed 32-bit words: channel-1 words first, then channel-2 words. It then emits the frame as ROMSIZE parallel pairs (x_o1, x_o2), one pair per clock with a data-valid strobe. It is the receive-side counterpart of the block that concatenates two parallel streams into one, and restores the original word pairing exactly.

## Interface
- ROMSIZE, 2, words per channel per frame; legal range 1..16.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- x_i  in  32  signed input word; sampled when write=1 and ready=1.
- write  in  1  input word valid, single-cycle qualifier.
- x_o1  out  32  signed channel-1 word of the current pair; registered.
- x_o2  out  32  signed channel-2 word of the current pair; registered.
- dv  out  1  pair valid; registered.
- ready  out  1  block accepts input; combinational, equals state==LOAD1 or LOAD2.
- done  out  1  one-cycle pulse after the last pair of a frame; registered.
- err  out  1  sticky: a write arrived while ready=0; cleared only by rst.

## Operation
- State machine: LOAD1 -> LOAD2 -> EMIT -> LOAD1.
- Position counter pos is 5 bits, unsigned.
- Storage: two arrays, buf1[0..ROMSIZE-1] and buf2[0..ROMSIZE-1]. Arrays are not reset; contents are don't-care until written.
- LOAD1: on write=1, buf1[pos]<=x_i.
  - If pos==ROMSIZE-1: pos<=0, state<=LOAD2.
  - Else pos<=pos+1.
  - write=0: no change; idle gaps of any length are allowed.
- LOAD2: same behaviour into buf2. On the last word: pos<=0, state<=EMIT.
- EMIT, pos<ROMSIZE: x_o1<=buf1[pos], x_o2<=buf2[pos], dv<=1, pos<=pos+1.
- EMIT, pos==ROMSIZE: dv<=0, done<=1, pos<=0, state<=LOAD1.
- done is 0 on every edge where it is not set.
- write=1 during EMIT: the word is discarded, err<=1, and no other state changes.
- x_o1 and x_o2 hold their last values while dv=0.
- Values pass through unmodified: no arithmetic, sign or width change.
- Reset (async, any time, including mid-frame): state=LOAD1, pos=0, x_o1=0, x_o2=0, dv=0, done=0, err=0, ready=1.
  - A partial frame is abandoned; the next accepted word is buf1[0].

## Timing
- Let edge E0 be the one that accepts the final channel-2 word.
- Edges E1..E_ROMSIZE: pair k (k=0..ROMSIZE-1) is registered on E(k+1), so dv=1 for exactly ROMSIZE consecutive cycles.
- Latency from the last input word to the first valid pair is 1 clock.
- Edge E(ROMSIZE+1): dv falls, done=1 for one cycle, ready rises.
  - A write on the cycle after E(ROMSIZE+1) is accepted as buf1[0] of the next frame.
- ready=0 from E0 until E(ROMSIZE+1), i.e. for ROMSIZE+1 cycles.
- A write in any of those cycles sets err.
- The upstream source must not drive write while ready=0.
- Best-case throughput with continuous writes: one frame per 3·ROMSIZE+1 cycles.
- done and dv are never high in the same cycle.

## Test plan
- Basic frame, ROMSIZE=4, rst pulse, then back-to-back writes 1..8:
  - Required: dv high 4 cycles with (x_o1,x_o2)=(1,5),(2,6),(3,7),(4,8), then done=1 for one cycle, err=0.
  - First dv follows the edge after the edge that accepts 8.
- Gapped input, ROMSIZE=4, words -1,-2,…,-8 with random write=0 gaps (0..3 cycles):
  - Required: pairs (-1,-5)…(-4,-8), sign preserved, dv cycles contiguous.
- Protocol violation: write=1 with x_i=99 during the second dv cycle of a frame.
  - Required: 99 discarded, remaining pairs unchanged, err=1 and stays 1 through the next frames until rst.
- Reset mid-frame, ROMSIZE=4: write 1..6, assert rst for one cycle, then write 10..17.
  - Required: outputs 0 and ready=1 immediately on rst, then pairs (10,14),(11,15),(12,16),(13,17).
- Back-to-back frames: the second frame (21..28) starts writing on the first cycle ready returns (the done cycle).
  - Required: second output (21,25)…(24,28), no err.
- Edge size, ROMSIZE=1: writes 7 then 9.
  - Required: a single dv cycle with (7,9), then done; ready low for exactly 2 cycles.

Source files
------------

// File: rtl/split.sv
// split: two-channel stream de-serializer.
// Receives one frame of 2*ROMSIZE signed words (all channel-1 words, then all
// channel-2 words) and replays it as ROMSIZE parallel pairs, one per clock.
//
// Ports:
//   clk    in   system clock, all state updates on posedge
//   rst    in   asynchronous active-high reset
//   x_i    in   signed input word, sampled when write=1 and ready=1
//   write  in   input word valid
//   x_o1   out  channel-1 word of the current pair (registered)
//   x_o2   out  channel-2 word of the current pair (registered)
//   dv     out  pair valid (registered)
//   ready  out  block accepts input (combinational, LOAD1 or LOAD2)
//   done   out  one-cycle pulse after the last pair of a frame (registered)
//   err    out  sticky flag: a write arrived while ready=0
module split #(
  parameter int unsigned ROMSIZE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] x_i,
  input  logic               write,
  output logic signed [31:0] x_o1,
  output logic signed [31:0] x_o2,
  output logic               dv,
  output logic               ready,
  output logic               done,
  output logic               err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned POS_W  = 5;
  // Index width is kept at least 1 so ROMSIZE=1 still has a legal select.
  localparam int unsigned IDX_W  = (ROMSIZE > 1) ? $clog2(ROMSIZE) : 1;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(ROMSIZE - 1);
  localparam logic [POS_W-1:0] POS_END  = POS_W'(ROMSIZE);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    LOAD1 = 2'd0,
    LOAD2 = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nx;
  logic [IDX_W-1:0] idx;

  // Frame storage; contents are don't-care until written, so no reset.
  logic signed [DATA_W-1:0] buf1 [DEPTH];
  logic signed [DATA_W-1:0] buf2 [DEPTH];

  logic                     we1;
  logic                     we2;
  logic signed [DATA_W-1:0] x_o1_nx;
  logic signed [DATA_W-1:0] x_o2_nx;
  logic                     dv_nx;
  logic                     done_nx;
  logic                     err_nx;

  assign idx   = pos[IDX_W-1:0];
  assign ready = (state == LOAD1) || (state == LOAD2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD1;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD1: if (write && (pos == POS_LAST)) state_nx = LOAD2;
      LOAD2: if (write && (pos == POS_LAST)) state_nx = EMIT;
      EMIT:  if (pos == POS_END)             state_nx = LOAD1;
      default: state_nx = LOAD1;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    pos_nx  = pos;
    we1     = 1'b0;
    we2     = 1'b0;
    x_o1_nx = x_o1;
    x_o2_nx = x_o2;
    dv_nx   = 1'b0;
    done_nx = 1'b0;
    // A write outside LOAD1/LOAD2 is dropped and only latches the error.
    err_nx  = err | (write & ~ready);
    unique case (state)
      LOAD1: begin
        if (write) begin
          we1    = 1'b1;
          pos_nx = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        end
      end
      LOAD2: begin
        if (write) begin
          we2    = 1'b1;
          pos_nx = (pos == POS_LAST) ? '0 : pos + POS_ONE;
        end
      end
      EMIT: begin
        if (pos < POS_END) begin
          x_o1_nx = buf1[idx];
          x_o2_nx = buf2[idx];
          dv_nx   = 1'b1;
          pos_nx  = pos + POS_ONE;
        end else begin
          done_nx = 1'b1;
          pos_nx  = '0;
        end
      end
      default: begin
        pos_nx = '0;
      end
    endcase
  end

  // Position counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      x_o1 <= '0;
      x_o2 <= '0;
      dv   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      pos  <= pos_nx;
      x_o1 <= x_o1_nx;
      x_o2 <= x_o2_nx;
      dv   <= dv_nx;
      done <= done_nx;
      err  <= err_nx;
    end
  end

  // Frame storage writes.
  always_ff @(posedge clk) begin
    if (we1) buf1[idx] <= x_i;
    if (we2) buf2[idx] <= x_i;
  end

endmodule

// File: tb/tb_split.sv
// tb_split: directed self-checking bench for split.
// Instance a uses ROMSIZE=4, instance b uses ROMSIZE=1; both share clk/rst.
module tb_split;

  logic clk;
  logic rst;

  logic signed [31:0] a_x_i, a_x_o1, a_x_o2;
  logic               a_write, a_dv, a_ready, a_done, a_err;
  logic signed [31:0] b_x_i, b_x_o1, b_x_o2;
  logic               b_write, b_dv, b_ready, b_done, b_err;

  int checks;
  int failures;

  split #(.ROMSIZE(4)) dut_a (
    .clk(clk), .rst(rst), .x_i(a_x_i), .write(a_write),
    .x_o1(a_x_o1), .x_o2(a_x_o2), .dv(a_dv), .ready(a_ready),
    .done(a_done), .err(a_err)
  );

  split #(.ROMSIZE(1)) dut_b (
    .clk(clk), .rst(rst), .x_i(b_x_i), .write(b_write),
    .x_o1(b_x_o1), .x_o2(b_x_o2), .dv(b_dv), .ready(b_ready),
    .done(b_done), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One word into instance a; returns 1 time unit after the accepting edge.
  task automatic wr_a(input logic signed [31:0] v);
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_a_ready: ready=%0b before word %0d, required 1", a_ready, v);
    end
    a_write = 1'b1;
    a_x_i   = v;
    @(posedge clk);
    #1;
    a_write = 1'b0;
  endtask

  task automatic wr_b(input logic signed [31:0] v);
    b_write = 1'b1;
    b_x_i   = v;
    @(posedge clk);
    #1;
    b_write = 1'b0;
  endtask

  // Called 1 unit after E0; checks ROMSIZE=4 pairs (a+step*k, b+step*k) and done.
  task automatic check_frame(input int a, input int b, input int step,
                             input bit inject, input string tag);
    logic signed [31:0] e1, e2;
    checks++;
    if (a_dv !== 1'b0 || a_ready !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_e0: dv=%0b ready=%0b done=%0b, required 0 0 0",
               tag, a_dv, a_ready, a_done);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 2) a_write = 1'b0;
      e1 = 32'(a + step * k);
      e2 = 32'(b + step * k);
      checks++;
      if (a_dv !== 1'b1 || a_done !== 1'b0 || a_ready !== 1'b0 ||
          a_x_o1 !== e1 || a_x_o2 !== e2) begin
        failures++;
        $display("FAIL %s_pair%0d: dv=%0b done=%0b ready=%0b x=(%0d,%0d), required 1 0 0 (%0d,%0d)",
                 tag, k, a_dv, a_done, a_ready, a_x_o1, a_x_o2, e1, e2);
      end
      if (inject && k == 1) begin
        a_write = 1'b1;
        a_x_i   = 32'sd99;
      end
    end
    @(posedge clk);
    #1;
    e1 = 32'(a + step * 3);
    e2 = 32'(b + step * 3);
    checks++;
    if (a_dv !== 1'b0 || a_done !== 1'b1 || a_ready !== 1'b1 ||
        a_x_o1 !== e1 || a_x_o2 !== e2) begin
      failures++;
      $display("FAIL %s_done: dv=%0b done=%0b ready=%0b x=(%0d,%0d), required 0 1 1 (%0d,%0d)",
               tag, a_dv, a_done, a_ready, a_x_o1, a_x_o2, e1, e2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_write = 1'b0; a_x_i = '0;
    b_write = 1'b0; b_x_i = '0;
    #1;
    checks++;
    if (a_x_o1 !== 0 || a_x_o2 !== 0 || a_dv !== 0 || a_done !== 0 ||
        a_err !== 0 || a_ready !== 1) begin
      failures++;
      $display("FAIL reset_a: x=(%0d,%0d) dv=%0b done=%0b err=%0b ready=%0b, required (0,0) 0 0 0 1",
               a_x_o1, a_x_o2, a_dv, a_done, a_err, a_ready);
    end
    checks++;
    if (b_x_o1 !== 0 || b_x_o2 !== 0 || b_dv !== 0 || b_done !== 0 ||
        b_err !== 0 || b_ready !== 1) begin
      failures++;
      $display("FAIL reset_b: x=(%0d,%0d) dv=%0b done=%0b err=%0b ready=%0b, required (0,0) 0 0 0 1",
               b_x_o1, b_x_o2, b_dv, b_done, b_err, b_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) wr_a(32'(i));
    check_frame(1, 5, 1, 1'b0, "basic");
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_err: err=%0b, required 0", a_err);
    end
  endtask

  // Starts writing in the done cycle of the previous frame.
  task automatic test_back_to_back();
    for (int i = 21; i <= 28; i++) wr_a(32'(i));
    check_frame(21, 25, 1, 1'b0, "b2b");
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_err: err=%0b, required 0", a_err);
    end
  endtask

  task automatic test_gapped();
    int g;
    // Idle one cycle so the done pulse is gone before gapped writes start.
    @(posedge clk);
    #1;
    checks++;
    if (a_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%0b one cycle after pulse, required 0", a_done);
    end
    for (int i = 1; i <= 8; i++) begin
      wr_a(-32'(i));
      if (i < 8) begin
        g = int'($urandom_range(0, 3));
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    check_frame(-1, -5, -1, 1'b0, "gapped");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 1; i <= 6; i++) wr_a(32'(i));
    rst = 1'b1;
    #1;
    checks++;
    if (a_x_o1 !== 0 || a_x_o2 !== 0 || a_ready !== 1 || a_dv !== 0 ||
        a_done !== 0 || a_err !== 0) begin
      failures++;
      $display("FAIL midrst: x=(%0d,%0d) ready=%0b dv=%0b done=%0b err=%0b, required (0,0) 1 0 0 0",
               a_x_o1, a_x_o2, a_ready, a_dv, a_done, a_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 10; i <= 17; i++) wr_a(32'(i));
    check_frame(10, 14, 1, 1'b0, "midrst");
  endtask

  task automatic test_protocol_violation();
    for (int i = 31; i <= 38; i++) wr_a(32'(i));
    check_frame(31, 35, 1, 1'b1, "viol");
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL viol_err: err=%0b, required 1", a_err);
    end
    // err must stay set through a clean following frame.
    for (int i = 41; i <= 48; i++) wr_a(32'(i));
    check_frame(41, 45, 1, 1'b0, "sticky");
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL sticky_err: err=%0b, required 1", a_err);
    end
  endtask

  task automatic test_romsize1();
    rst = 1'b1;
    #1;
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err=%0b after rst, required 0", a_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_b(32'sd7);
    checks++;
    if (b_ready !== 1'b1 || b_dv !== 1'b0) begin
      failures++;
      $display("FAIL r1_after7: ready=%0b dv=%0b, required 1 0", b_ready, b_dv);
    end
    wr_b(32'sd9);
    checks++;
    if (b_ready !== 1'b0 || b_dv !== 1'b0) begin
      failures++;
      $display("FAIL r1_e0: ready=%0b dv=%0b, required 0 0", b_ready, b_dv);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_dv !== 1'b1 || b_ready !== 1'b0 || b_done !== 1'b0 ||
        b_x_o1 !== 32'sd7 || b_x_o2 !== 32'sd9) begin
      failures++;
      $display("FAIL r1_pair: dv=%0b ready=%0b done=%0b x=(%0d,%0d), required 1 0 0 (7,9)",
               b_dv, b_ready, b_done, b_x_o1, b_x_o2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_dv !== 1'b0 || b_done !== 1'b1 || b_ready !== 1'b1 || b_err !== 1'b0) begin
      failures++;
      $display("FAIL r1_done: dv=%0b done=%0b ready=%0b err=%0b, required 0 1 1 0",
               b_dv, b_done, b_ready, b_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_done !== 1'b0 || b_dv !== 1'b0) begin
      failures++;
      $display("FAIL r1_after: done=%0b dv=%0b, required 0 0", b_done, b_dv);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_reset_mid_frame();
    test_protocol_violation();
    test_romsize1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
